one_unit_seq: RTL and testbench



---
 rtl/one_unit_seq.sv | 117 +++++++++++
 tb/tb_one_unit_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_unit_seq.sv
// Sequencer for the FastICA one-unit weight-update pipeline: loads weights, walks
// the stage enables once per iteration, then loops or finishes on the comparator result.
module one_unit_seq #(
   parameter int N_STAGE  = 5,
   parameter int MAX_ITER = 16,
   parameter int ITER_W   = 5
) (
   input  logic               clk_ctrl,
   input  logic               rst_n_ctrl,
   input  logic               start,
   input  logic               abort,
   input  logic               conv_valid,
   input  logic               conv_flag,
   output logic               ld_w,
   output logic               sel_fb,
   output logic [N_STAGE-1:0] en_stage,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [ITER_W-1:0]  iter_cnt
);

   localparam int SW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
   localparam logic [SW-1:0]     LAST_STAGE = SW'(N_STAGE - 1);
   localparam logic [ITER_W-1:0] ITER_MAX   = ITER_W'(MAX_ITER);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;

   state_t            state, state_nxt;
   logic [SW-1:0]     stage, stage_nxt;
   logic [ITER_W-1:0] iter_nxt;
   logic              timeout_nxt;
   logic              sel_fb_nxt;
   logic              start_seen, start_seen_nxt;

   always_ff @(posedge clk_ctrl or negedge rst_n_ctrl) begin
      if (!rst_n_ctrl) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      stage_nxt   = stage;
      iter_nxt    = iter_cnt;
      timeout_nxt = timeout;
      sel_fb_nxt  = sel_fb;
      // A start is captured for one cycle in IDLE and acted on the cycle after.
      start_seen_nxt = (state == IDLE) && !start_seen && start && !abort;
      case (state)
         IDLE: begin
            if (start_seen && !abort) begin
               state_nxt   = LOAD;
               iter_nxt    = '0;
               timeout_nxt = 1'b0;
               sel_fb_nxt  = 1'b0;
            end
         end
         LOAD: begin
            if (abort) state_nxt = IDLE;
            else begin
               state_nxt = RUN;
               stage_nxt = '0;
            end
         end
         RUN: begin
            if (abort) state_nxt = IDLE;
            else if (stage == LAST_STAGE) begin
               state_nxt = CHECK;
               if (iter_cnt != ITER_MAX) iter_nxt = iter_cnt + ITER_W'(1);
            end else begin
               stage_nxt = stage + SW'(1);
            end
         end
         CHECK: begin
            if (abort) state_nxt = IDLE;
            else if (conv_valid) begin
               if (conv_flag) state_nxt = DONE;
               else if (iter_cnt == ITER_MAX) begin
                  state_nxt   = DONE;
                  timeout_nxt = 1'b1;
               end else begin
                  state_nxt  = LOAD;
                  sel_fb_nxt = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are flopped from the next state so they line up with the state register.
   always_ff @(posedge clk_ctrl or negedge rst_n_ctrl) begin
      if (!rst_n_ctrl) begin
         stage      <= '0;
         start_seen <= 1'b0;
         iter_cnt   <= '0;
         timeout    <= 1'b0;
         sel_fb     <= 1'b0;
         ld_w       <= 1'b0;
         en_stage   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         stage      <= stage_nxt;
         start_seen <= start_seen_nxt;
         iter_cnt   <= iter_nxt;
         timeout    <= timeout_nxt;
         sel_fb     <= sel_fb_nxt;
         ld_w       <= (state_nxt == LOAD);
         en_stage   <= (state_nxt == RUN) ? (N_STAGE'(1) << stage_nxt) : '0;
         busy       <= (state_nxt != IDLE);
         done       <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_one_unit_seq.sv
// Directed bench for one_unit_seq: expected output events are queued as stimulus
// is driven and compared by a monitor whenever the sequencer shows activity.
module tb_one_unit_seq;

   localparam int N_STAGE  = 5;
   localparam int MAX_ITER = 16;
   localparam int ITER_W   = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0, abort = 1'b0, conv_valid = 1'b0, conv_flag = 1'b0;
   logic ld_w, sel_fb, busy, done, timeout;
   logic [N_STAGE-1:0] en_stage;
   logic [ITER_W-1:0]  iter_cnt;

   int checks = 0;
   int errors = 0;
   int ld_count = 0;
   int en_count = 0;
   logic [13:0] sb[$];

   one_unit_seq #(.N_STAGE(N_STAGE), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
      .clk_ctrl(clk), .rst_n_ctrl(rst_n), .start(start), .abort(abort),
      .conv_valid(conv_valid), .conv_flag(conv_flag), .ld_w(ld_w), .sel_fb(sel_fb),
      .en_stage(en_stage), .busy(busy), .done(done), .timeout(timeout), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] mk(input logic ld, input logic [4:0] en, input logic dn,
                                      input logic sf, input logic to, input logic [4:0] it);
      return {ld, en, dn, sf, to, it};
   endfunction

   // Iteration j: one load cycle then n_en stage cycles, all before iter_cnt advances.
   task automatic push_iter(input int j, input int n_en);
      sb.push_back(mk(1'b1, 5'd0, 1'b0, j > 1, 1'b0, 5'(j - 1)));
      for (int i = 0; i < n_en; i++)
         sb.push_back(mk(1'b0, 5'(1 << i), 1'b0, j > 1, 1'b0, 5'(j - 1)));
   endtask

   task automatic push_done(input int n, input logic to, input logic sf);
      sb.push_back(mk(1'b0, 5'd0, 1'b1, sf, to, 5'(n)));
   endtask

   always @(negedge clk) begin
      if (rst_n && (ld_w || en_stage != '0 || done)) begin
         if (ld_w) ld_count++;
         if (en_stage != '0) begin
            en_count++;
            check("en_onehot", $countones(en_stage), 1);
         end
         check("sb_expected_event", 32'(sb.size() != 0), 1);
         if (sb.size() != 0)
            check("sb_event", 32'({ld_w, en_stage, done, sel_fb, timeout, iter_cnt}), 32'(sb.pop_front()));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_check();
      bit hit = 1'b0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge clk);
         hit = busy && !ld_w && (en_stage == '0) && !done;
      end
      check("wait_check", 32'(hit), 1);
   endtask

   task automatic wait_en(input logic [N_STAGE-1:0] val);
      bit hit = 1'b0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge clk);
         hit = (en_stage == val);
      end
      check("wait_en", 32'(hit), 1);
   endtask

   task automatic respond(input logic flag, input int delay);
      cyc(delay);
      conv_valid = 1'b1;
      conv_flag  = flag;
      @(negedge clk);
      conv_valid = 1'b0;
      conv_flag  = 1'b0;
   endtask

   initial begin
      // reset values
      #1 rst_n = 1'b0;
      cyc(2);
      check("rst_outputs", 32'({ld_w, sel_fb, en_stage, busy, done, timeout, iter_cnt}), 0);
      rst_n = 1'b1;
      cyc(2);
      check("rst_idle_busy", busy, 0);

      // single converging iteration, exact cycle timing
      push_iter(1, N_STAGE);
      pulse_start();
      check("t1_pending_busy", busy, 0);
      check("t1_pending_ld", ld_w, 0);
      cyc(1);
      check("t1_ld", ld_w, 1);
      check("t1_busy", busy, 1);
      check("t1_sel_fb", sel_fb, 0);
      for (int i = 0; i < N_STAGE; i++) begin
         cyc(1);
         check("t1_en_walk", en_stage, 32'(1 << i));
      end
      cyc(1);
      check("t1_check_en", en_stage, 0);
      check("t1_check_busy", busy, 1);
      check("t1_check_iter", iter_cnt, 1);
      push_done(1, 1'b0, 1'b0);
      respond(1'b1, 4);
      check("t1_done", done, 1);
      check("t1_timeout", timeout, 0);
      check("t1_iter", iter_cnt, 1);
      cyc(1);
      check("t1_done_once", done, 0);
      check("t1_idle", busy, 0);

      // converge on iteration 3
      push_iter(1, N_STAGE);
      pulse_start();
      for (int j = 1; j <= 3; j++) begin
         wait_check();
         if (j < 3) begin
            push_iter(j + 1, N_STAGE);
            respond(1'b0, 1);
         end else begin
            push_done(3, 1'b0, 1'b1);
            respond(1'b1, 2);
         end
      end
      check("t3_done", done, 1);
      check("t3_iter", iter_cnt, 3);
      check("t3_timeout", timeout, 0);
      cyc(1);

      // never converges: runs to MAX_ITER
      ld_count = 0;
      en_count = 0;
      push_iter(1, N_STAGE);
      pulse_start();
      for (int j = 1; j <= MAX_ITER; j++) begin
         wait_check();
         if (j < MAX_ITER) push_iter(j + 1, N_STAGE);
         else push_done(MAX_ITER, 1'b1, 1'b1);
         respond(1'b0, j % 3);
      end
      check("t2_done", done, 1);
      check("t2_iter", iter_cnt, MAX_ITER);
      check("t2_timeout", timeout, 1);
      check("t2_ld_pulses", ld_count, MAX_ITER);
      check("t2_en_pulses", en_count, MAX_ITER * N_STAGE);
      cyc(3);
      check("t2_timeout_sticky", timeout, 1);
      check("t2_iter_held", iter_cnt, MAX_ITER);
      check("t2_sel_fb_held", sel_fb, 1);

      // new start clears status, then abort in iteration 2 stage 2
      push_iter(1, N_STAGE);
      pulse_start();
      cyc(1);
      check("t4_clear_timeout", timeout, 0);
      check("t4_clear_iter", iter_cnt, 0);
      check("t4_clear_sel_fb", sel_fb, 0);
      wait_check();
      push_iter(2, 3);
      respond(1'b0, 0);
      wait_en(5'b00100);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t4_abort_en", en_stage, 0);
      check("t4_abort_busy", busy, 0);
      check("t4_abort_done", done, 0);
      check("t4_abort_iter", iter_cnt, 1);
      for (int k = 0; k < 3; k++) respond(1'b1, 1);
      check("t4_conv_ignored", busy, 0);
      check("t4_iter_frozen", iter_cnt, 1);
      check("t4_sb_drained", sb.size(), 0);

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      cyc(3);
      check("t5a_stay_idle", busy, 0);

      // abort and conv_valid together in CHECK
      push_iter(1, N_STAGE);
      pulse_start();
      wait_check();
      abort = 1'b1;
      conv_valid = 1'b1;
      conv_flag = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      conv_valid = 1'b0;
      conv_flag = 1'b0;
      check("t5b_busy", busy, 0);
      check("t5b_no_done", done, 0);
      check("t5b_iter", iter_cnt, 1);

      // start held during RUN, and start during the DONE cycle, both ignored
      push_iter(1, N_STAGE);
      pulse_start();
      wait_en(5'b00001);
      start = 1'b1;
      wait_check();
      start = 1'b0;
      push_done(1, 1'b0, 1'b0);
      respond(1'b1, 1);
      check("t5c_done", done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc(3);
      check("t5c_done_start_ignored", busy, 0);
      check("t5c_sb_drained", sb.size(), 0);

      // asynchronous reset in the middle of iteration 2
      push_iter(1, N_STAGE);
      pulse_start();
      wait_check();
      push_iter(2, 2);
      respond(1'b0, 0);
      wait_en(5'b00010);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_outputs", 32'({ld_w, sel_fb, en_stage, busy, done, timeout, iter_cnt}), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      cyc(4);
      check("t6_stay_idle", busy, 0);
      check("t6_sb_drained", sb.size(), 0);
      push_iter(1, N_STAGE);
      pulse_start();
      wait_check();
      push_done(1, 1'b0, 1'b0);
      respond(1'b1, 0);
      check("t6_rerun_done", done, 1);
      check("t6_rerun_iter", iter_cnt, 1);
      cyc(2);
      check("final_sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
